// File: rtl/csr_access_unit.sv
// CSR instruction execution unit: reads the old CSR value, applies the RW/RS/RC operation,
// writes back through a one-cycle strobe, and returns the old value with a legality flag.
module csr_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_rs1_idx,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_illegal,
    output logic        csr_wen,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] rs1Data_q, rs1Data_d;
    logic [4:0]  rs1Idx_q, rs1Idx_d;
    logic [31:0] old_q, old_d;

    logic [31:0] src;
    logic [31:0] newValue;
    logic        writeIntended;
    logic        addrLegal;
    logic        illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1Data_q <= '0;
            rs1Idx_q  <= '0;
            old_q     <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rs1Data_q <= rs1Data_d;
            rs1Idx_q  <= rs1Idx_d;
            old_q     <= old_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        rs1Data_d = rs1Data_q;
        rs1Idx_d  = rs1Idx_q;
        old_d     = old_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d  = req_funct3;
                    addr_d    = req_addr;
                    rs1Data_d = req_rs1_data;
                    rs1Idx_d  = req_rs1_idx;
                    state_d   = READ;
                end
            end
            READ: begin
                old_d   = csr_rdata;
                state_d = WRITE;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Immediate forms use the rs1 field as a zero-extended 5-bit operand.
    assign src = funct3_q[2] ? {27'd0, rs1Idx_q} : rs1Data_q;

    always_comb begin
        newValue = '0;
        unique case (funct3_q[1:0])
            2'b01:   newValue = src;
            2'b10:   newValue = old_q | src;
            2'b11:   newValue = old_q & ~src;
            default: newValue = '0;
        endcase
    end

    assign writeIntended = (funct3_q[1:0] == 2'b01) || (rs1Idx_q != 5'd0);
    assign addrLegal     = (addr_q == 12'hB00) || (addr_q == 12'hB80) ||
                           (addr_q == 12'hF11) || (addr_q == 12'hF12);
    assign illegal       = (funct3_q[1:0] == 2'b00) || !addrLegal ||
                           (writeIntended && (addr_q[11:10] == 2'b11));

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_illegal = resp_valid && illegal;
    assign resp_rdata   = (resp_valid && !illegal) ? old_q : 32'd0;
    // Reset is sampled combinationally so a reset landing in WRITE suppresses the strobe at once.
    assign csr_wen      = (state_q == WRITE) && writeIntended && !illegal && !rst;
    assign csr_wdata    = (state_q == WRITE) ? newValue : 32'd0;
    assign csr_addr     = addr_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Scoreboard bench for csr_access_unit with a small CSR register file model (cycle counter,
// writable register, two read-only IDs).
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_rs1_idx;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        illegal;
    } resp_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
    } wr_t;

    resp_t respQ[$];
    wr_t   wrQ[$];

    logic [31:0] mcycleReg = 32'd0;
    logic [31:0] scratchReg = 32'h11112222;

    always #5 clk = ~clk;

    csr_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs1_data (req_rs1_data),
        .req_rs1_idx  (req_rs1_idx),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_illegal (resp_illegal),
        .csr_wen      (csr_wen),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata)
    );

    // Register file model: 0xB00 counts every cycle unless written.
    always @(posedge clk) begin
        if (csr_wen && csr_addr == 12'hB00) mcycleReg <= csr_wdata;
        else                                mcycleReg <= mcycleReg + 32'd1;
        if (csr_wen && csr_addr == 12'hB80) scratchReg <= csr_wdata;
    end

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            12'hB00: csr_rdata = mcycleReg;
            12'hB80: csr_rdata = scratchReg;
            12'hF11: csr_rdata = 32'h79737978;
            12'hF12: csr_rdata = 32'h00000005;
            default: csr_rdata = 32'd0;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (csr_wen === 1'b1) begin
            if (wrQ.size() == 0) begin
                checkOutput("unexpected_wen", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wrQ.pop_front();
                checkOutput("wen_addr", {20'd0, csr_addr}, {20'd0, w.addr});
                checkOutput("wen_wdata", csr_wdata, w.wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic waitReady();
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) checkOutput("ready_timeout", 32'd1, 32'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [31:0] data, input logic [4:0] idx,
                                 input bit useMcycle, input logic [31:0] expRdata,
                                 input bit expIll, input bit expWrite,
                                 input logic [31:0] expWdata, input int stall);
        resp_t r;
        resp_t got;
        wr_t   w;
        int    n;
        waitReady();
        req_funct3   = f3;
        req_addr     = addr;
        req_rs1_data = data;
        req_rs1_idx  = idx;
        req_valid    = 1'b1;
        // The counter advances once on the accepting edge before READ samples it.
        r.rdata   = useMcycle ? mcycleReg + 32'd1 : expRdata;
        r.illegal = expIll;
        respQ.push_back(r);
        if (expWrite) begin
            w.addr  = addr;
            w.wdata = expWdata;
            wrQ.push_back(w);
        end
        tick();
        req_valid = 1'b0;
        checkOutput("busy_ready", {31'd0, req_ready}, 32'd0);
        n = 0;
        while (resp_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checkOutput("latency", n, 32'd2);
        got = respQ.pop_front();
        checkOutput("resp_rdata", resp_rdata, got.rdata);
        checkOutput("resp_illegal", {31'd0, resp_illegal}, {31'd0, got.illegal});
        for (int i = 0; i < stall; i++) begin
            req_valid    = 1'b1;
            req_funct3   = 3'b001;
            req_addr     = 12'hB80;
            req_rs1_data = 32'h00000BAD;
            req_rs1_idx  = 5'd1;
            tick();
            checkOutput("stall_valid", {31'd0, resp_valid}, 32'd1);
            checkOutput("stall_rdata", resp_rdata, got.rdata);
            checkOutput("stall_illegal", {31'd0, resp_illegal}, {31'd0, got.illegal});
            checkOutput("stall_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        checkOutput("ready_after_hs", {31'd0, req_ready}, 32'd1);
        checkOutput("valid_after_hs", {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic resetInWrite(input logic [11:0] addr, input logic [31:0] data);
        waitReady();
        req_funct3   = 3'b001;
        req_addr     = addr;
        req_rs1_data = data;
        req_rs1_idx  = 5'd1;
        req_valid    = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("rst_write_wen", {31'd0, csr_wen}, 32'd0);
        tick();
        rst = 1'b0;
        checkOutput("rst_write_idle", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_write_valid", {31'd0, resp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 12'h000;
        req_rs1_data = 32'd0;
        req_rs1_idx  = 5'd0;
        resp_ready   = 1'b0;
        repeat (3) tick();
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        checkOutput("rst_resp_illegal", {31'd0, resp_illegal}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_csr_wen", {31'd0, csr_wen}, 32'd0);
        checkOutput("rst_csr_addr", {20'd0, csr_addr}, 32'd0);
        checkOutput("rst_csr_wdata", csr_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // f3, addr, rs1_data, rs1_idx, useMcycle, expRdata, expIll, expWrite, expWdata, stall
        applyStimulus(3'b010, 12'hF11, 32'h0,    5'd0, 1'b0, 32'h79737978, 1'b0, 1'b0, 32'h0,   0);
        applyStimulus(3'b001, 12'hB00, 32'h100,  5'd4, 1'b1, 32'h0,        1'b0, 1'b1, 32'h100, 0);
        applyStimulus(3'b001, 12'hB80, 32'hF,    5'd5, 1'b0, 32'h11112222, 1'b0, 1'b1, 32'hF,   0);
        applyStimulus(3'b111, 12'hB80, 32'hFFFF, 5'd3, 1'b0, 32'hF,        1'b0, 1'b1, 32'hC,   0);
        applyStimulus(3'b001, 12'hF12, 32'h55,   5'd6, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   0);
        applyStimulus(3'b100, 12'hB00, 32'h55,   5'd6, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   0);
        applyStimulus(3'b010, 12'h300, 32'h0,    5'd0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   0);
        applyStimulus(3'b110, 12'hF11, 32'h0,    5'd1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,   0);
        applyStimulus(3'b010, 12'hF12, 32'h0,    5'd0, 1'b0, 32'h5,        1'b0, 1'b0, 32'h0,   0);
        applyStimulus(3'b010, 12'hB80, 32'hF0,   5'd7, 1'b0, 32'hC,        1'b0, 1'b1, 32'hFC,  5);
        applyStimulus(3'b011, 12'hB80, 32'h0F,   5'd2, 1'b0, 32'hFC,       1'b0, 1'b1, 32'hF0,  0);
        resetInWrite(12'hB80, 32'hDEAD);
        applyStimulus(3'b010, 12'hB80, 32'h0,    5'd0, 1'b0, 32'hF0,       1'b0, 1'b0, 32'h0,   0);

        repeat (2) tick();
        checkOutput("wq_empty", wrQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

Interface
REQ-001 SHALL have port: clk  input  1  clock; all state updates on posedge clk.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req_valid  input  1  CSR instruction request from execute stage.
REQ-004 SHALL have port: req_ready  output  1  unit can accept a request.
REQ-005 SHALL have port: req_funct3  input  3  CSR op: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
REQ-006 SHALL have port: req_addr  input  12  CSR address.
REQ-007 SHALL have port: req_rs1_data  input  32  rs1 value, used by register forms.
REQ-008 SHALL have port: req_rs1_idx  input  5  rs1 index; serves as uimm for immediate forms.
REQ-009 SHALL have port: resp_valid  output  1  result available.
REQ-010 SHALL have port: resp_ready  input  1  downstream accepts result.
REQ-011 SHALL have port: resp_rdata  output  32  old CSR value, written to rd.
REQ-012 SHALL have port: resp_illegal  output  1  illegal-instruction flag.
REQ-013 SHALL have port: csr_wen  output  1  write strobe to CSR register file.
REQ-014 SHALL have port: csr_addr  output  12  CSR register file address.
REQ-015 SHALL have port: csr_wdata  output  32  CSR register file write data.
REQ-016 SHALL have port: csr_rdata  input  32  combinational CSR register file read data.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> WRITE -> RESP -> IDLE; one state per cycle except RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; request accepted on req_valid && req_ready; req_* latched on acceptance.
REQ-019 SHALL drive csr_addr with the latched address from READ through RESP; csr_addr holds its last value otherwise.
REQ-020 SHALL, in READ, capture csr_rdata into an internal old-value register.
REQ-021 SHALL select src = funct3[2] ? zero-extended req_rs1_idx : req_rs1_data.
REQ-022 SHALL compute new value from captured old value: RW new=src; RS new=old|src; RC new=old&~src.
REQ-023 SHALL mark a write intended for RW/RWI always; for RS/RC/RSI/RCI only when req_rs1_idx != 0.
REQ-024 SHALL treat as legal addresses only 0xB00, 0xB80, 0xF11, 0xF12.
REQ-025 SHALL flag illegal when funct3 is 000 or 100, address not legal, or write intended with addr[11:10]==2'b11.
REQ-026 SHALL pulse csr_wen=1 for exactly one cycle in WRITE, with csr_wdata=new value, iff write intended and not illegal; csr_wen=0 in every other cycle.
REQ-027 SHALL pass through WRITE even when no write occurs (fixed latency).
REQ-028 SHALL assert resp_valid in RESP with resp_rdata=captured old value and resp_illegal as computed; on illegal, resp_rdata=0.
REQ-029 SHALL hold resp_valid, resp_rdata and resp_illegal stable while resp_valid && !resp_ready.
REQ-030 SHALL return to IDLE on resp_valid && resp_ready; req_ready rises the following cycle (no same-cycle accept).
REQ-031 SHALL give latency: accept at cycle T, resp_valid first high at T+3.
REQ-032 SHALL accept that counter CSRs advance between READ and WRITE; RS/RC writes use the READ-cycle value.

Reset
REQ-033 SHALL on rst force IDLE, req_ready=1 after reset, resp_valid=0, resp_illegal=0, resp_rdata=0, csr_wen=0, csr_addr=0, csr_wdata=0, old-value register=0.
REQ-034 SHALL, if rst asserts in any state, including WRITE, issue no csr_wen in that cycle and discard the in-flight request.

Verification
REQ-035 SHALL cover: CSRRS addr 0xF11, rs1_idx=0 -> resp_rdata=0x79737978, illegal=0, csr_wen never high, resp_valid at T+3.
REQ-036 SHALL cover: CSRRW addr 0xB00, rs1_data=0x100 -> one csr_wen pulse in WRITE with wdata=0x100; resp_rdata=mcycle at READ.
REQ-037 SHALL cover: CSRRCI addr 0xB80, uimm=0x03, old=0x0000000F -> csr_wdata=0x0000000C, resp_rdata=0x0000000F.
REQ-038 SHALL cover: CSRRW addr 0xF12, and separately funct3=100 addr 0xB00 -> resp_illegal=1, resp_rdata=0, no csr_wen.
REQ-039 SHALL cover: resp_ready low 5 cycles in RESP -> outputs stable, req_ready=0, second req_valid ignored; after handshake, req_ready=1 next cycle.
REQ-040 SHALL cover: rst asserted in WRITE of a CSRRW -> csr_wen=0, FSM IDLE next cycle, target CSR unchanged.
